// File: rtl/hex_disp_pkg.sv
// Shared types, character codes and helpers for the HEX display arbiter.
// Codes are 4-bit values for the downstream 7-segment decoders.
package hex_disp_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int MSG_W      = 4 * NUM_DIGITS;

  localparam logic [3:0] CH_F     = 4'h0;
  localparam logic [3:0] CH_I     = 4'h1;
  localparam logic [3:0] CH_N     = 4'h2;
  localparam logic [3:0] CH_S     = 4'h3;
  localparam logic [3:0] CH_H     = 4'h4;
  localparam logic [3:0] CH_BLANK = 4'hF;

  typedef enum logic {
    IDLE,
    SHOW
  } state_e;

  // Output digit i takes message digit (i - offset) mod NUM_DIGITS, so characters move toward HEX5.
  function automatic logic [MSG_W-1:0] rotate_msg(input logic [MSG_W-1:0] msg,
                                                  input logic [2:0] offset);
    logic [MSG_W-1:0] r;
    int src;
    r = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      src = (i - int'(offset) + NUM_DIGITS) % NUM_DIGITS;
      r[4*i +: 4] = msg[4*src +: 4];
    end
    return r;
  endfunction

  function automatic logic [2:0] pick_highest(input logic [2:0] r);
    logic [2:0] g;
    if (r[2])      g = 3'b100;
    else if (r[1]) g = 3'b010;
    else if (r[0]) g = 3'b001;
    else           g = 3'b000;
    return g;
  endfunction

endpackage

// File: rtl/hex_display_arbiter_tick_divider.sv
// Free-running tick divider: counts 0..TICK_MAX and flags the terminal count.
// clr restarts the count from zero so the first tick lands TICK_MAX+1 cycles later.
module tick_divider #(
  parameter int TICK_MAX = 49_999_999
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_MAX < 1) ? 1 : $clog2(TICK_MAX + 1);
  localparam logic [CNT_W-1:0] TC = CNT_W'(TICK_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hex_display_arbiter.sv
// Fixed-priority owner of the six HEX digits (requester 2 highest) with minimum-hold
// preemption and optional per-tick rotation of the owner's message.
module hex_display_arbiter
  import hex_disp_pkg::*;
#(
  parameter int         TICK_MAX   = 49_999_999,
  parameter int         MIN_HOLD   = 2,
  parameter logic [3:0] BLANK_CODE = CH_BLANK
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [2:0]       req,
  input  logic [2:0]       rot_en,
  input  logic [MSG_W-1:0] msg0,
  input  logic [MSG_W-1:0] msg1,
  input  logic [MSG_W-1:0] msg2,
  output logic [2:0]       grant,
  output logic [MSG_W-1:0] code_out,
  output logic             step
);

  localparam int HOLD_W = (MIN_HOLD < 1) ? 1 : $clog2(MIN_HOLD + 1);
  localparam logic [MSG_W-1:0] BLANK_MSG = {NUM_DIGITS{BLANK_CODE}};

  state_e            state_q, state_d;
  logic [2:0]        grant_q, grant_d;
  logic [2:0]        offset_q, offset_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [MSG_W-1:0]  code_q, code_d;
  logic              step_q, step_d;

  logic              tick;
  logic              clr;
  logic [2:0]        higher_req;
  logic [MSG_W-1:0]  owner_msg;

  tick_divider #(
    .TICK_MAX (TICK_MAX)
  ) u_tick_divider (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .clr      (clr),
    .tick     (tick)
  );

  assign higher_req = req & ~(grant_q | (grant_q - 3'd1));

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    offset_d = offset_q;
    hold_d   = hold_q;
    step_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d  = pick_highest(req);
          state_d  = SHOW;
          offset_d = '0;
          hold_d   = '0;
        end
      end
      SHOW: begin
        if (!(|(req & grant_q))) begin
          offset_d = '0;
          hold_d   = '0;
          grant_d  = pick_highest(req);
          if (!(|req)) state_d = IDLE;
        end else if (tick && (|higher_req) && (int'(hold_q) + 1 >= MIN_HOLD)) begin
          // The tick being evaluated completes a hold period, so it counts toward MIN_HOLD.
          grant_d  = pick_highest(higher_req);
          offset_d = '0;
          hold_d   = '0;
        end else if (tick) begin
          if (int'(hold_q) < MIN_HOLD) hold_d = hold_q + HOLD_W'(1);
          if (|(rot_en & grant_q)) begin
            offset_d = (offset_q == 3'd5) ? 3'd0 : offset_q + 3'd1;
            step_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign clr = (grant_d != grant_q);

  always_comb begin
    case (grant_d)
      3'b001:  owner_msg = msg0;
      3'b010:  owner_msg = msg1;
      3'b100:  owner_msg = msg2;
      default: owner_msg = BLANK_MSG;
    endcase
    code_d = (grant_d == 3'b000) ? BLANK_MSG : rotate_msg(owner_msg, offset_d);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      offset_q <= '0;
      hold_q   <= '0;
      code_q   <= BLANK_MSG;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      offset_q <= offset_d;
      hold_q   <= hold_d;
      code_q   <= code_d;
      step_q   <= step_d;
    end
  end

  assign grant    = grant_q;
  assign code_out = code_q;
  assign step     = step_q;

endmodule
